// File: rtl/bp_pkg.sv
// Shared constants for the branch predictor: 2-bit counter encodings and
// the helper that recovers a branch's actual direction from EXE feedback.
package bp_pkg;

    localparam logic [1:0] BP_SNT = 2'b00;
    localparam logic [1:0] BP_WNT = 2'b01;
    localparam logic [1:0] BP_WT  = 2'b10;
    localparam logic [1:0] BP_ST  = 2'b11;

    localparam logic [1:0] BP_CTR_RESET = BP_WNT;
    localparam logic [1:0] BP_CTR_ALLOC = BP_WT;

    localparam logic BP_TAKEN     = 1'b1;
    localparam logic BP_NOT_TAKEN = 1'b0;

    // A failed prediction means the branch went the other way.
    function automatic logic bp_outcome(input logic predict, input logic fail);
        return predict ^ fail;
    endfunction

endpackage

// File: rtl/bp_sat_ctr.sv
// Next-value function of a 2-bit saturating counter:
// counts up on taken, down on not-taken, and holds at either end.
module bp_sat_ctr
    import bp_pkg::*;
(
    input  logic [1:0] ctr,
    input  logic       taken,
    output logic [1:0] ctr_next
);

    always_comb begin
        ctr_next = ctr;
        if (taken == BP_TAKEN) begin
            if (ctr != BP_ST) ctr_next = ctr + 2'd1;
        end else begin
            if (ctr != BP_SNT) ctr_next = ctr - 2'd1;
        end
    end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped dynamic branch predictor: combinational fetch query,
// learning from EXE feedback, saturating statistics and a sticky protocol flag.
module branch_predictor
    import bp_pkg::*;
#(
    parameter int IDX_W  = 6,
    parameter int TAG_W  = 8,
    parameter int STAT_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [31:0]       q_pc,
    output logic              q_hit,
    output logic              q_taken,
    output logic [31:0]       q_target,
    input  logic              upd_valid,
    input  logic [31:0]       upd_pc,
    input  logic [31:0]       upd_target,
    input  logic              upd_predict,
    input  logic              upd_success,
    input  logic              upd_fail,
    input  logic              bp_clr,
    output logic [STAT_W-1:0] stat_branches,
    output logic [STAT_W-1:0] stat_miss,
    output logic              protocol_err
);

    localparam int               DEPTH    = 1 << IDX_W;
    localparam logic [STAT_W-1:0] STAT_ONE = {{(STAT_W-1){1'b0}}, 1'b1};
    localparam logic [STAT_W-1:0] STAT_MAX = {STAT_W{1'b1}};

    logic              r_valid  [DEPTH];
    logic [TAG_W-1:0]  r_tag    [DEPTH];
    logic [1:0]        r_ctr    [DEPTH];
    logic [31:0]       r_target [DEPTH];
    logic [STAT_W-1:0] r_stat_branches;
    logic [STAT_W-1:0] r_stat_miss;
    logic              r_protocol_err;

    logic [IDX_W-1:0]  w_q_idx;
    logic [TAG_W-1:0]  w_q_tag;
    logic [IDX_W-1:0]  w_u_idx;
    logic [TAG_W-1:0]  w_u_tag;
    logic              w_q_hit;
    logic              w_q_taken;
    logic              w_u_hit;
    logic              w_upd_legal;
    logic              w_upd_illegal;
    logic              w_upd_taken;
    logic [1:0]        w_ctr_next;
    logic              w_unused_upd_pc;

    assign w_q_idx = q_pc[IDX_W+1:2];
    assign w_q_tag = q_pc[IDX_W+TAG_W+1:IDX_W+2];
    assign w_u_idx = upd_pc[IDX_W+1:2];
    assign w_u_tag = upd_pc[IDX_W+TAG_W+1:IDX_W+2];
    assign w_unused_upd_pc = ^{upd_pc[31:IDX_W+TAG_W+2], upd_pc[1:0]};

    // Query reads registered state only, so a same-cycle update is not visible.
    assign w_q_hit   = r_valid[w_q_idx] && (r_tag[w_q_idx] == w_q_tag);
    assign w_q_taken = w_q_hit && r_ctr[w_q_idx][1];
    assign q_hit     = w_q_hit;
    assign q_taken   = w_q_taken;
    assign q_target  = w_q_taken ? r_target[w_q_idx] : q_pc + 32'd4;

    assign w_u_hit       = r_valid[w_u_idx] && (r_tag[w_u_idx] == w_u_tag);
    assign w_upd_legal   = upd_valid && (upd_success ^ upd_fail);
    assign w_upd_illegal = upd_valid && !(upd_success ^ upd_fail);
    assign w_upd_taken   = bp_outcome(upd_predict, upd_fail);

    bp_sat_ctr u_sat_ctr (
        .ctr      (r_ctr[w_u_idx]),
        .taken    (w_upd_taken),
        .ctr_next (w_ctr_next)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_valid[i]  <= 1'b0;
                r_tag[i]    <= '0;
                r_ctr[i]    <= BP_CTR_RESET;
                r_target[i] <= '0;
            end
        end else if (bp_clr) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_valid[i] <= 1'b0;
                r_ctr[i]   <= BP_CTR_RESET;
            end
        end else if (w_upd_legal) begin
            if (w_u_hit) begin
                r_ctr[w_u_idx] <= w_ctr_next;
                if (w_upd_taken) r_target[w_u_idx] <= upd_target;
            end else if (w_upd_taken) begin
                r_valid[w_u_idx]  <= 1'b1;
                r_tag[w_u_idx]    <= w_u_tag;
                r_target[w_u_idx] <= upd_target;
                r_ctr[w_u_idx]    <= BP_CTR_ALLOC;
            end
        end
    end

    // Statistics count every legally resolved branch and never wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stat_branches <= '0;
            r_stat_miss     <= '0;
            r_protocol_err  <= 1'b0;
        end else begin
            if (w_upd_legal) begin
                if (r_stat_branches != STAT_MAX) r_stat_branches <= r_stat_branches + STAT_ONE;
                if (upd_fail && (r_stat_miss != STAT_MAX)) r_stat_miss <= r_stat_miss + STAT_ONE;
            end
            if (w_upd_illegal) r_protocol_err <= 1'b1;
        end
    end

    assign stat_branches = r_stat_branches;
    assign stat_miss     = r_stat_miss;
    assign protocol_err  = r_protocol_err;

endmodule

// File: tb/tb_branch_predictor.sv
// Self-checking bench for branch_predictor: directed scenarios plus random
// feedback compared against a table-level reference model of the predictor.
module tb_branch_predictor;

   logic        clk = 1'b0;
   logic        rstN;
   logic [31:0] qPc;
   logic        qHit;
   logic        qTaken;
   logic [31:0] qTarget;
   logic        updValid;
   logic [31:0] updPc;
   logic [31:0] updTarget;
   logic        updPredict;
   logic        updSuccess;
   logic        updFail;
   logic        bpClr;
   logic [31:0] statBranches;
   logic [31:0] statMiss;
   logic        protocolErr;

   int nAsserts = 0;
   int nFails   = 0;

   // Reference model: one record per table slot, counter kept as a 0..3 integer.
   bit          mValid  [64];
   int          mTag    [64];
   int          mCtr    [64];
   logic [31:0] mTarget [64];
   longint      mBranches;
   longint      mMiss;
   bit          mErr;

   always #5 clk = ~clk;

   branch_predictor dut (
      .clk           (clk),
      .rst_n         (rstN),
      .q_pc          (qPc),
      .q_hit         (qHit),
      .q_taken       (qTaken),
      .q_target      (qTarget),
      .upd_valid     (updValid),
      .upd_pc        (updPc),
      .upd_target    (updTarget),
      .upd_predict   (updPredict),
      .upd_success   (updSuccess),
      .upd_fail      (updFail),
      .bp_clr        (bpClr),
      .stat_branches (statBranches),
      .stat_miss     (statMiss),
      .protocol_err  (protocolErr)
   );

   // One comparison: counts it, and on mismatch counts and reports the failure.
   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      nAsserts++;
      assert (observed === expected)
      else begin
         nFails++;
         $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
      end
   endtask

   // The model resets every slot to invalid, weakly not-taken, zero target.
   task automatic modelReset();
      for (int i = 0; i < 64; i++) begin
         mValid[i] = 0; mTag[i] = 0; mCtr[i] = 1; mTarget[i] = '0;
      end
      mBranches = 0; mMiss = 0; mErr = 0;
   endtask

   function automatic int slotOf(input logic [31:0] pc);
      return int'((pc / 4) % 64);
   endfunction

   function automatic int tagOf(input logic [31:0] pc);
      return int'((pc / 256) % 256);
   endfunction

   task automatic modelQuery(input logic [31:0] pc, output logic hit, output logic taken, output logic [31:0] target);
      int s;
      s = slotOf(pc);
      hit    = mValid[s] && (mTag[s] == tagOf(pc));
      taken  = hit && (mCtr[s] >= 2);
      target = taken ? mTarget[s] : pc + 32'd4;
   endtask

   // The model applies one clock edge's worth of feedback.
   task automatic modelUpdate(input logic uv, input logic [31:0] upc, input logic [31:0] utgt,
                              input logic upred, input logic usucc, input logic ufail, input logic clr);
      int  s;
      bit  legal;
      bit  actualTaken;
      bit  hit;
      s = slotOf(upc);
      legal = uv && (usucc != ufail);
      actualTaken = (upred != ufail);
      if (uv && (usucc == ufail)) mErr = 1;
      if (legal) begin
         if (mBranches < 64'hFFFF_FFFF) mBranches++;
         if (ufail && mMiss < 64'hFFFF_FFFF) mMiss++;
      end
      if (clr) begin
         for (int i = 0; i < 64; i++) begin
            mValid[i] = 0; mCtr[i] = 1;
         end
      end else if (legal) begin
         hit = mValid[s] && (mTag[s] == tagOf(upc));
         if (hit) begin
            if (actualTaken) begin
               mCtr[s] = (mCtr[s] == 3) ? 3 : mCtr[s] + 1;
               mTarget[s] = utgt;
            end else begin
               mCtr[s] = (mCtr[s] == 0) ? 0 : mCtr[s] - 1;
            end
         end else if (actualTaken) begin
            mValid[s] = 1; mTag[s] = tagOf(upc); mTarget[s] = utgt; mCtr[s] = 2;
         end
      end
   endtask

   // One clock cycle: drive inputs, check the query before the edge,
   // then advance the model and check the registered outputs after the edge.
   task automatic applyStimulus(input logic [31:0] qpc, input logic uv, input logic [31:0] upc,
                                input logic [31:0] utgt, input logic upred, input logic usucc,
                                input logic ufail, input logic clr, input bit chkStats);
      logic        eHit;
      logic        eTaken;
      logic [31:0] eTarget;
      @(negedge clk);
      qPc = qpc; updValid = uv; updPc = upc; updTarget = utgt;
      updPredict = upred; updSuccess = usucc; updFail = ufail; bpClr = clr;
      #1;
      modelQuery(qpc, eHit, eTaken, eTarget);
      checkOutput("q_hit", {31'd0, qHit}, {31'd0, eHit});
      checkOutput("q_taken", {31'd0, qTaken}, {31'd0, eTaken});
      checkOutput("q_target", qTarget, eTarget);
      @(posedge clk);
      modelUpdate(uv, upc, utgt, upred, usucc, ufail, clr);
      #1;
      checkOutput("protocol_err", {31'd0, protocolErr}, {31'd0, mErr});
      if (chkStats) begin
         checkOutput("stat_branches", statBranches, 32'(mBranches));
         checkOutput("stat_miss", statMiss, 32'(mMiss));
      end
   endtask

   task automatic queryOnly(input logic [31:0] qpc);
      applyStimulus(qpc, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
   endtask

   task automatic update(input logic [31:0] qpc, input logic [31:0] upc, input logic [31:0] utgt,
                         input logic upred, input logic usucc, input logic ufail);
      applyStimulus(qpc, 1'b1, upc, utgt, upred, usucc, ufail, 1'b0, 1'b1);
   endtask

   initial begin
      logic [31:0] rPc;
      logic [31:0] rQ;
      logic        pHit;
      logic        pTaken;
      logic [31:0] pTgt;
      logic        actual;
      logic        pred;
      logic        succ;
      logic        fl;

      rstN = 1'b0; qPc = 32'h0040_0000; updValid = 1'b0; updPc = '0; updTarget = '0;
      updPredict = 1'b0; updSuccess = 1'b0; updFail = 1'b0; bpClr = 1'b0;
      modelReset();
      #12;
      $display("[TB] reset state");
      checkOutput("rst_q_hit", {31'd0, qHit}, 32'd0);
      checkOutput("rst_q_taken", {31'd0, qTaken}, 32'd0);
      checkOutput("rst_q_target", qTarget, 32'h0040_0004);
      checkOutput("rst_stat_branches", statBranches, 32'd0);
      checkOutput("rst_stat_miss", statMiss, 32'd0);
      @(negedge clk);
      rstN = 1'b1;

      $display("[TB] allocation on mispredicted taken branch, same-cycle query sees old state");
      update(32'h0040_0010, 32'h0040_0010, 32'h0040_0100, 1'b0, 1'b0, 1'b1);
      queryOnly(32'h0040_0010);
      checkOutput("alloc_target", qTarget, 32'h0040_0100);
      checkOutput("alloc_miss", statMiss, 32'd1);

      $display("[TB] counter saturation");
      for (int i = 0; i < 4; i++) update(32'h0040_0010, 32'h0040_0010, 32'h0040_0100, 1'b1, 1'b1, 1'b0);
      queryOnly(32'h0040_0010);
      for (int i = 0; i < 2; i++) update(32'h0040_0010, 32'h0040_0010, 32'h0040_0100, 1'b1, 1'b0, 1'b1);
      queryOnly(32'h0040_0010);
      checkOutput("weak_nt_hit", {31'd0, qHit}, 32'd1);
      checkOutput("weak_nt_taken", {31'd0, qTaken}, 32'd0);

      $display("[TB] aliasing on shared index");
      update(32'h0040_1010, 32'h0040_1010, 32'h0040_2000, 1'b0, 1'b0, 1'b1);
      queryOnly(32'h0040_0010);
      checkOutput("alias_old_hit", {31'd0, qHit}, 32'd0);
      queryOnly(32'h0040_1010);
      checkOutput("alias_new_target", qTarget, 32'h0040_2000);

      $display("[TB] illegal feedback");
      update(32'h0040_1010, 32'h0040_1010, 32'h0040_3000, 1'b0, 1'b1, 1'b1);
      checkOutput("illegal_err", {31'd0, protocolErr}, 32'd1);
      queryOnly(32'h0040_1010);
      update(32'h0040_1010, 32'h0040_1010, 32'h0040_3000, 1'b1, 1'b0, 1'b0);

      $display("[TB] random feedback against model");
      for (int n = 0; n < 400; n++) begin
         rPc = 32'h0040_0000 + ($urandom_range(0, 3) << 12) + ($urandom_range(0, 7) << 2);
         rQ  = ($urandom_range(0, 3) == 0) ? rPc
             : 32'h0040_0000 + ($urandom_range(0, 3) << 12) + ($urandom_range(0, 7) << 2);
         modelQuery(rPc, pHit, pTaken, pTgt);
         pred   = ($urandom_range(0, 3) != 0) ? pTaken : 1'($urandom_range(0, 1));
         actual = 1'($urandom_range(0, 1));
         succ   = (pred == actual);
         fl     = !succ;
         if ($urandom_range(0, 15) == 0) begin
            succ = 1'($urandom_range(0, 1));
            fl   = succ;
         end
         applyStimulus(rQ, 1'($urandom_range(0, 9) < 7), rPc,
                       32'h0040_0000 + ($urandom_range(0, 255) << 2), pred, succ, fl, 1'b0, 1'b1);
      end

      $display("[TB] clear together with an update");
      update(32'h0040_0020, 32'h0040_0020, 32'h0040_0400, 1'b0, 1'b0, 1'b1);
      applyStimulus(32'h0040_0020, 1'b1, 32'h0040_0030, 32'h0040_0500, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
      checkOutput("clr_keeps_err", {31'd0, protocolErr}, 32'd1);
      queryOnly(32'h0040_0020);
      checkOutput("clr_hit_a", {31'd0, qHit}, 32'd0);
      queryOnly(32'h0040_0030);
      checkOutput("clr_hit_b", {31'd0, qHit}, 32'd0);

      $display("[TB] asynchronous reset mid-cycle");
      @(posedge clk);
      #3;
      rstN = 1'b0;
      #1;
      checkOutput("async_err", {31'd0, protocolErr}, 32'd0);
      checkOutput("async_branches", statBranches, 32'd0);
      checkOutput("async_miss", statMiss, 32'd0);
      checkOutput("async_q_target", qTarget, qPc + 32'd4);

      $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFails);
      $finish;
   end

endmodule

// File: doc/branch_predictor.md
# branch_predictor

Dynamic branch predictor for the 5-stage MIPS pipeline. It answers fetch-stage queries with a taken/not-taken prediction and a predicted target. It learns from the resolution feedback that the EXE stage produces: the prediction it used, plus the success/fail pair. Storage is a direct-mapped table of 2-bit saturating counters with tag, valid and target per entry, plus saturating statistics counters.

## Interface
Parameters:
- IDX_W, 6: index width; table depth 2^IDX_W; index = pc[IDX_W+1:2]
- TAG_W, 8: tag width; tag = pc[IDX_W+TAG_W+1:IDX_W+2]
- STAT_W, 32: width of statistics counters

Ports:
- clk  in  1  system clock; all state updates on the rising edge
- rst_n  in  1  reset; asynchronous, active-low
- q_pc  in  32  fetch PC being queried
- q_hit  out  1  entry valid and tag matches q_pc
- q_taken  out  1  prediction; feeds the pipeline branch_predict bit
- q_target  out  32  predicted next PC
- upd_valid  in  1  one resolved branch this cycle (EXE branch_inst, not stalled)
- upd_pc  in  32  PC of the resolved branch
- upd_target  in  32  computed branch target
- upd_predict  in  1  prediction carried down the pipe with this branch
- upd_success  in  1  EXE branch_predict_success
- upd_fail  in  1  EXE branch_predict_fail
- bp_clr  in  1  synchronous invalidate of the whole table
- stat_branches  out  STAT_W  resolved-branch count
- stat_miss  out  STAT_W  misprediction count
- protocol_err  out  1  sticky; set on illegal feedback

## Operation
- Counter encoding: 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T.
- Query, combinational from registered state:
  - q_hit = valid[idx] && tag[idx]==q_tag.
  - q_taken = q_hit && ctr[idx][1].
  - q_target = q_taken ? target[idx] : q_pc+4.
- Update, when upd_valid and exactly one of upd_success/upd_fail is set:
  - Actual outcome: taken = upd_predict ^ upd_fail.
  - Entry hit, taken: ctr increments, saturating at 11; target[idx] <= upd_target.
  - Entry hit, not taken: ctr decrements, saturating at 00; target unchanged.
  - Entry miss, taken: allocate (valid=1, tag written, target=upd_target, ctr=10), replacing any occupant.
  - Entry miss, not taken: no table change.
  - stat_branches += 1; if upd_fail, stat_miss += 1. Both saturate at all-ones and never wrap.
- Illegal feedback: upd_valid with success==fail (both 0 or both 1).
  - No table or stat change.
  - protocol_err <= 1; stays set until reset.
- bp_clr: all valid <= 0 and all ctr <= 01. Stats and protocol_err are kept. bp_clr wins over a simultaneous update.
- Reset: all valid 0, all ctr 01, all target 0, all tag 0, stats 0, protocol_err 0.
- Output values during reset: q_hit=0, q_taken=0, q_target=q_pc+4.

## Timing
- Query latency 0: the outputs follow q_pc in the same cycle.
- Update takes effect at the next rising edge. The first query to observe it is in the following cycle.
- Same-cycle query and update to the same index: the query returns the pre-update value. There is no bypass.
- At most one update per cycle; upd_* inputs are ignored when upd_valid=0.
- Reset asserted mid-operation clears all state immediately, independent of clk.
- Stats, protocol_err and the table change only on clock edges.

## Structure
- Shared package bp_pkg:
  - counter constants BP_SNT/BP_WNT/BP_WT/BP_ST
  - counter reset value (BP_WNT) and allocation value (BP_WT)
  - outcome helper constants
- Sub-module bp_sat_ctr: combinational 2-bit saturating next-value function (inputs ctr, taken; output ctr_next). The main module instantiates it once, on the update path.
- Table arrays (valid, tag, ctr, target) are plain registers so that reset and bp_clr can clear them in one cycle.

## Test plan
- Reset, then query 0x00400000 -> q_hit=0, q_taken=0, q_target=0x00400004; stat_branches=0, stat_miss=0.
- Update (pc 0x00400010, target 0x00400100, predict 0, fail 1), then query 0x00400010 -> q_hit=1, q_taken=1, q_target=0x00400100; stat_miss=1.
- Counter saturation, same pc:
  - Three taken updates -> ctr 11; a fourth keeps 11.
  - Then two not-taken updates -> ctr 01, so q_taken=0 and q_hit=1.
- Aliasing: allocate pc 0x00400010, then a taken update on pc 0x00401010 (same index, different tag) -> query 0x00400010 gives q_hit=0, and query 0x00401010 gives its own target.
- Same cycle, a query and an allocating update to the same index -> query shows q_hit=0 that cycle and q_hit=1 the next cycle.
- Illegal feedback, then clear:
  - upd_valid with success=fail=1 -> protocol_err=1; table and stats unchanged.
  - bp_clr together with an update -> all entries invalid; protocol_err still 1.
  - rst_n low mid-cycle -> protocol_err=0 and stats=0 immediately.
